spi_slave: RTL and testbench

- SPI slave/responder; the opposite end of the link from the team's SPI master.
- Oversamples SCLK, SSbar and MOSI on the system clock `clk`, shifts words MSB-first, and exposes a valid/ready transmit interface and a valid/ready receive interface to the APB-side logic.
- Supports all four CPOL/CPHA modes, selected at elaboration time.
- Used for loopback verification of the master and as a peripheral front-end.

---
 rtl/spi_slave_if.sv | 33 +++
 rtl/spi_slave.sv | 172 +++++++++++++++++
 tb/tb_spi_slave.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// spi_slave_if : SPI pins plus valid/ready host side of spi_slave
// Revision     : 1.0
// ============================================================================
interface spi_slave_if #(
    parameter int WORD_LENGTH = 8
);
    logic                   SCLK;
    logic                   SSbar;
    logic                   MOSI;
    logic                   MISO;
    logic [WORD_LENGTH-1:0] TX_DATA;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [WORD_LENGTH-1:0] RX_DATA;
    logic                   rx_valid;
    logic                   rx_ready;
    logic                   overrun;
    logic                   underrun;
    logic                   busy;

    modport slave (
        input  SCLK, SSbar, MOSI, TX_DATA, tx_valid, rx_ready,
        output MISO, tx_ready, RX_DATA, rx_valid, overrun, underrun, busy
    );

    modport master (
        output SCLK, SSbar, MOSI, TX_DATA, tx_valid, rx_ready,
        input  MISO, tx_ready, RX_DATA, rx_valid, overrun, underrun, busy
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// spi_slave : oversampled SPI responder, MSB-first, valid/ready TX and RX
// Revision  : 1.0
// ============================================================================
module spi_slave #(
    parameter int WORD_LENGTH = 8,
    parameter int SPI_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int               CNT_W      = $clog2(WORD_LENGTH + 1);
    localparam logic [CNT_W-1:0] C_WORD_END = CNT_W'(WORD_LENGTH);
    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WORD_LENGTH - 1);
    localparam logic             C_CPOL     = ((SPI_MODE / 2) % 2) == 1;
    localparam logic             C_CPHA     = (SPI_MODE % 2) == 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   ss_prev;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;

    logic [WORD_LENGTH-1:0] tx_hold;
    logic                   hold_full;
    logic [WORD_LENGTH-1:0] tx_shift;
    logic [WORD_LENGTH-1:0] rx_shift;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   sclk_toggle;
    logic                   lead_edge;
    logic                   trail_edge;
    logic                   sample_edge;
    logic                   shift_edge;
    logic                   ss_fall;
    logic                   word_done;
    logic                   word_load;

    // Synchronizers idle at the inactive bus levels so reset never fakes an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_sync <= {SYNC_STAGES{C_CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= C_CPOL;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.SSbar};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign ss_s        = ss_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];

    assign sclk_toggle = sclk_s != sclk_prev;
    assign lead_edge   = sclk_toggle && (sclk_s != C_CPOL);
    assign trail_edge  = sclk_toggle && (sclk_s == C_CPOL);
    assign sample_edge = (state == ST_ACTIVE) && (C_CPHA ? trail_edge : lead_edge);
    assign shift_edge  = (state == ST_ACTIVE) && (C_CPHA ? lead_edge : trail_edge);
    assign ss_fall     = !ss_s && ss_prev;
    assign word_done   = bit_cnt == C_WORD_END;
    assign word_load   = ((state == ST_IDLE) && ss_fall) ||
                         ((state == ST_ACTIVE) && word_done && !ss_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.busy   = 1'b0;
        bus.MISO   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall) begin
                    state_next = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                bus.busy = 1'b1;
                bus.MISO = tx_shift[WORD_LENGTH-1];
                if (ss_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.tx_ready = !hold_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_hold      <= '0;
            hold_full    <= 1'b0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            bus.RX_DATA  <= '0;
            bus.rx_valid <= 1'b0;
            bus.overrun  <= 1'b0;
            bus.underrun <= 1'b0;
        end else begin
            bus.overrun  <= 1'b0;
            bus.underrun <= 1'b0;

            if (bus.rx_valid && bus.rx_ready) begin
                bus.rx_valid <= 1'b0;
            end

            // A capture coinciding with an empty-register load is kept for the next word
            if (bus.tx_valid && !hold_full) begin
                tx_hold   <= bus.TX_DATA;
                hold_full <= 1'b1;
            end

            if (word_load) begin
                if (hold_full) begin
                    tx_shift  <= tx_hold;
                    hold_full <= 1'b0;
                end else begin
                    tx_shift     <= '0;
                    bus.underrun <= 1'b1;
                end
            end

            // Completion runs even after deselect so a word finishing with SSbar still reports
            if (word_done) begin
                bus.RX_DATA  <= rx_shift;
                bus.rx_valid <= 1'b1;
                bus.overrun  <= bus.rx_valid && !bus.rx_ready;
                bit_cnt      <= '0;
            end else if (state == ST_ACTIVE) begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[WORD_LENGTH-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                // The first shift edge of a word only presents the freshly loaded MSB
                if (shift_edge && (bit_cnt != '0) && !word_load) begin
                    tx_shift <= {tx_shift[WORD_LENGTH-2:0], 1'b0};
                end
                if (ss_s && !(sample_edge && (bit_cnt == C_LAST_BIT))) begin
                    bit_cnt <= '0;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// tb_spi_slave : drives one spi_slave per SPI mode from a bit-banged master
// Revision     : 1.0
// ============================================================================
module tb_spi_slave;
    localparam int WL = 8;
    localparam int H  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] sclk_a     = 4'b1100;
    logic [3:0] ss_a       = 4'hF;
    logic [3:0] mosi_a     = 4'h0;
    logic [3:0] tx_valid_a = 4'h0;
    logic [3:0] rx_ready_a = 4'hF;
    logic [7:0] tx_data    = 8'h00;
    logic [3:0] miso_a, tx_ready_a, rx_valid_a, ovr_a, und_a, busy_a;
    logic [7:0] rx_data_a [4];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        spi_slave_if #(.WORD_LENGTH(WL)) bus ();
        assign bus.SCLK     = sclk_a[k];
        assign bus.SSbar    = ss_a[k];
        assign bus.MOSI     = mosi_a[k];
        assign bus.TX_DATA  = tx_data;
        assign bus.tx_valid = tx_valid_a[k];
        assign bus.rx_ready = rx_ready_a[k];
        assign miso_a[k]     = bus.MISO;
        assign tx_ready_a[k] = bus.tx_ready;
        assign rx_data_a[k]  = bus.RX_DATA;
        assign rx_valid_a[k] = bus.rx_valid;
        assign ovr_a[k]      = bus.overrun;
        assign und_a[k]      = bus.underrun;
        assign busy_a[k]     = bus.busy;
        spi_slave #(.WORD_LENGTH(WL), .SPI_MODE(k), .SYNC_STAGES(2)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
    end

    int         checks   = 0;
    int         failures = 0;
    int         cur      = 0;
    logic       prev_rxv = 1'b0;
    int         ovr_cnt  = 0;
    int         und_cnt  = 0;
    int         exp_und  = 0;
    logic [7:0] rx_q   [$];
    logic [7:0] tx_q   [$];
    logic [7:0] exp_mi [$];

    // Observer: new RX words, overrun and underrun pulses of the selected slave
    always @(negedge clk) begin
        if (rx_valid_a[cur] && !prev_rxv) rx_q.push_back(rx_data_a[cur]);
        prev_rxv = rx_valid_a[cur];
        if (ovr_a[cur]) ovr_cnt++;
        if (und_a[cur]) und_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: every word load hands over the oldest queued TX word, or zeros
    task automatic model_load();
        if (tx_q.size() > 0) exp_mi.push_back(tx_q.pop_front());
        else begin
            exp_mi.push_back(8'h00);
            exp_und++;
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        exp_mi.delete();
        ovr_cnt = 0;
        und_cnt = 0;
        exp_und = 0;
    endtask

    task automatic tx_load(input int m, input logic [7:0] d);
        int waited = 0;
        while (!tx_ready_a[m] && waited < 50) begin
            tick(1);
            waited++;
        end
        checks++;
        if (!tx_ready_a[m]) begin
            failures++;
            $display("FAIL tx_ready_wait mode=%0d got=0 exp=1", m);
        end
        tx_data = d;
        tx_valid_a[m] = 1'b1;
        tx_q.push_back(d);
        tick(1);
        tx_valid_a[m] = 1'b0;
    endtask

    task automatic ss_low(input int m, input logic first_msb);
        cur = m;
        mosi_a[m] = first_msb;
        ss_a[m] = 1'b0;
        model_load();
        tick(H);
    endtask

    task automatic ss_high(input int m);
        ss_a[m] = 1'b1;
        tick(2 * H);
    endtask

    task automatic spi_bits(input int m, input logic [7:0] mo, input int nbits,
                            input logic next_msb, output logic [7:0] mi);
        logic c = ((m >> 1) & 1) == 1;
        logic p = (m & 1) == 1;
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (p) mosi_a[m] = mo[i];
            else   mi[i] = miso_a[m];
            sclk_a[m] = ~c;
            tick(H);
            if (p) mi[i] = miso_a[m];
            sclk_a[m] = c;
            if (!p) mosi_a[m] = (i > 0) ? mo[i-1] : next_msb;
            tick(H);
        end
        if (nbits == 8) model_load();
    endtask

    task automatic xfer(input int m, input logic [7:0] tx, input logic [7:0] mo,
                        output logic [7:0] mi);
        tx_load(m, tx);
        ss_low(m, mo[7]);
        spi_bits(m, mo, 8, 1'b0, mi);
        ss_high(m);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({miso_a[k], tx_ready_a[k], rx_valid_a[k], ovr_a[k], und_a[k], busy_a[k]} !== 6'b010000) begin
                failures++;
                $display("FAIL reset_flags mode=%0d got=%b exp=010000", k,
                         {miso_a[k], tx_ready_a[k], rx_valid_a[k], ovr_a[k], und_a[k], busy_a[k]});
            end
            checks++;
            if (rx_data_a[k] !== 8'h00) begin
                failures++;
                $display("FAIL reset_rx_data mode=%0d got=%h exp=00", k, rx_data_a[k]);
            end
        end
        rst = 1'b1;
        tick(3);
    endtask

    task automatic test_mode(input int m, input logic [7:0] tx, input logic [7:0] mo);
        logic [7:0] mi;
        logic [7:0] e;
        clear_obs();
        xfer(m, tx, mo, mi);
        e = exp_mi.pop_front();
        checks++;
        if (mi !== e) begin
            failures++;
            $display("FAIL mode%0d_miso_word got=%h exp=%h", m, mi, e);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== mo) begin
            failures++;
            $display("FAIL mode%0d_rx_word got=%h n=%0d exp=%h", m,
                     (rx_q.size() > 0) ? rx_q[0] : 8'h00, rx_q.size(), mo);
        end
        checks++;
        if (tx_ready_a[m] !== 1'b1 || und_cnt != exp_und || ovr_cnt != 0) begin
            failures++;
            $display("FAIL mode%0d_status got=%b/%0d/%0d exp=1/%0d/0", m,
                     tx_ready_a[m], und_cnt, ovr_cnt, exp_und);
        end
    endtask

    task automatic test_back_to_back(input int m, input logic [7:0] t0, input logic [7:0] t1,
                                     input logic [7:0] w0, input logic [7:0] w1);
        logic [7:0] mi0, mi1, e0, e1;
        clear_obs();
        tx_load(m, t0);
        ss_low(m, w0[7]);
        tx_load(m, t1);
        spi_bits(m, w0, 8, w1[7], mi0);
        spi_bits(m, w1, 8, 1'b0, mi1);
        ss_high(m);
        e0 = exp_mi.pop_front();
        e1 = exp_mi.pop_front();
        checks++;
        if (mi0 !== e0 || mi1 !== e1) begin
            failures++;
            $display("FAIL b2b_miso mode=%0d got=%h,%h exp=%h,%h", m, mi0, mi1, e0, e1);
        end
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== w0 || rx_q[1] !== w1) begin
            failures++;
            $display("FAIL b2b_rx mode=%0d n=%0d exp=%h,%h", m, rx_q.size(), w0, w1);
        end
        checks++;
        if (und_cnt != exp_und || ovr_cnt != 0) begin
            failures++;
            $display("FAIL b2b_flags mode=%0d got=und%0d/ovr%0d exp=und%0d/ovr0", m, und_cnt, ovr_cnt, exp_und);
        end
    endtask

    task automatic test_overrun_underrun();
        logic [7:0] tx, mi0, mi1, e0, e1;
        tx = 8'($urandom_range(1, 255));
        clear_obs();
        rx_ready_a[0] = 1'b0;
        tx_load(0, tx);
        ss_low(0, 1'b0);
        spi_bits(0, 8'h55, 8, 1'b1, mi0);
        spi_bits(0, 8'hAA, 8, 1'b0, mi1);
        ss_high(0);
        e0 = exp_mi.pop_front();
        e1 = exp_mi.pop_front();
        checks++;
        if (mi0 !== e0 || mi1 !== e1) begin
            failures++;
            $display("FAIL ovr_miso got=%h,%h exp=%h,%h", mi0, mi1, e0, e1);
        end
        checks++;
        if (ovr_cnt != 1 || und_cnt != exp_und) begin
            failures++;
            $display("FAIL ovr_und_pulses got=ovr%0d/und%0d exp=ovr1/und%0d", ovr_cnt, und_cnt, exp_und);
        end
        checks++;
        if (rx_data_a[0] !== 8'hAA || rx_valid_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL ovr_rx_held got=%h/%b exp=aa/1", rx_data_a[0], rx_valid_a[0]);
        end
        rx_ready_a[0] = 1'b1;
        tick(2);
        checks++;
        if (rx_valid_a[0] !== 1'b0) begin
            failures++;
            $display("FAIL rx_accept got=%b exp=0", rx_valid_a[0]);
        end
    endtask

    task automatic test_abort(input int m);
        logic [7:0] mi, e, t2;
        t2 = 8'($urandom);
        clear_obs();
        tx_load(m, 8'($urandom));
        ss_low(m, 1'b1);
        spi_bits(m, 8'($urandom), 5, 1'b0, mi);
        ss_a[m] = 1'b1;
        tick(3);
        checks++;
        if (busy_a[m] !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy mode=%0d got=%b exp=0", m, busy_a[m]);
        end
        tick(2 * H);
        checks++;
        if (rx_q.size() != 0) begin
            failures++;
            $display("FAIL abort_no_rx mode=%0d got=%0d words exp=0", m, rx_q.size());
        end
        void'(exp_mi.pop_front());
        xfer(m, t2, 8'hC3, mi);
        e = exp_mi.pop_front();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hC3 || mi !== e) begin
            failures++;
            $display("FAIL abort_next mode=%0d rx_n=%0d mi=%h exp=c3/%h", m, rx_q.size(), mi, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi, t;
        t = 8'($urandom);
        clear_obs();
        tx_load(0, 8'($urandom));
        ss_low(0, 1'b1);
        spi_bits(0, 8'hB7, 3, 1'b0, mi);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy_a[0], miso_a[0], tx_ready_a[0], rx_valid_a[0]} !== 4'b0010 || rx_data_a[0] !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got=%b/%h exp=0010/00",
                     {busy_a[0], miso_a[0], tx_ready_a[0], rx_valid_a[0]}, rx_data_a[0]);
        end
        ss_a[0] = 1'b1;
        mosi_a[0] = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        tx_q.delete();
        clear_obs();
        xfer(0, t, 8'h99, mi);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h99 || mi !== t) begin
            failures++;
            $display("FAIL reset_recover rx_n=%0d mi=%h exp=99/%h", rx_q.size(), mi, t);
        end
    endtask

    initial begin
        test_reset();
        test_mode(0, 8'hA5, 8'h3C);
        for (int m = 1; m < 4; m++) test_mode(m, 8'h81, 8'h7E);
        for (int m = 0; m < 4; m++) test_mode(m, 8'($urandom), 8'($urandom));
        test_back_to_back(0, 8'hF0, 8'h0F, 8'h11, 8'h22);
        test_back_to_back(int'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                          8'($urandom), 8'($urandom));
        test_overrun_underrun();
        test_abort(int'($urandom_range(0, 3)));
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
